// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div sequencer.
// The master modport is the pipeline side; the slave modport is the sequencer.
interface muldiv_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            flush;
   logic            resp_valid;
   logic [XLEN-1:0] resp_result;
   logic            busy;

   modport master (
      output req_valid, funct3, op1, op2, flush,
      input  req_ready, resp_valid, resp_result, busy
   );

   modport slave (
      input  req_valid, funct3, op1, op2, flush,
      output req_ready, resp_valid, resp_result, busy
   );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: one shared unsigned shift-add / restoring-divide core,
// one iteration per cycle for XLEN cycles, with sign fix-up and single-cycle special cases.
module muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   muldiv_seq_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b;
   logic [2:0]        fn;
   logic              neg;

   logic              a_signed_op, b_signed_op, a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_ge;
   logic [XLEN-1:0]   div_rem, div_val;
   logic [2*XLEN-1:0] acc_next, prod;
   logic [XLEN-1:0]   calc_res;

   // Accept-cycle decode: operand magnitudes, sign flags and the no-iteration cases.
   always_comb begin
      a_signed_op = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                    (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
      b_signed_op = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
      a_neg       = a_signed_op & bus.op1[XLEN-1];
      b_neg       = b_signed_op & bus.op2[XLEN-1];
      a_abs       = a_neg ? -bus.op1 : bus.op1;
      b_abs       = b_neg ? -bus.op2 : bus.op2;
      div_zero    = bus.funct3[2] && (bus.op2 == '0);
      div_ovf     = bus.funct3[2] && !bus.funct3[0] && (bus.op1 == SMIN) && (bus.op2 == '1);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = bus.funct3[1] ? bus.op1 : '1;
      else if (div_ovf)
         special_res = bus.funct3[1] ? '0 : bus.op1;
   end

   // acc holds {partial product high, multiplier} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : '0);
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge    = div_shift >= {1'b0, b};
      div_diff  = div_shift - {1'b0, b};
      div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      acc_next  = fn[2] ? {div_rem, acc[XLEN-2:0], div_ge} : {mul_sum, acc[XLEN-1:1]};
      prod      = neg ? -acc_next : acc_next;
      div_val   = fn[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
      if (fn[2])
         calc_res = neg ? -div_val : div_val;
      else if (fn[1:0] != 2'd0)
         calc_res = prod[2*XLEN-1:XLEN];
      else
         calc_res = prod[XLEN-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         acc             <= '0;
         b               <= '0;
         fn              <= '0;
         neg             <= 1'b0;
         bus.req_ready   <= 1'b1;
         bus.busy        <= 1'b0;
         bus.resp_valid  <= 1'b0;
         bus.resp_result <= '0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid && !bus.flush) begin
                  fn            <= bus.funct3;
                  // Remainder takes the dividend's sign; everything else the xor of both.
                  neg           <= (bus.funct3 == 3'd6) ? a_neg : (a_neg ^ b_neg);
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  if (special) begin
                     bus.resp_result <= special_res;
                     bus.resp_valid  <= 1'b1;
                     state           <= DONE;
                  end else begin
                     acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_abs : b_abs)};
                     b     <= bus.funct3[2] ? b_abs : a_abs;
                     cnt   <= CW'(XLEN - 1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.flush) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.busy      <= 1'b0;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) begin
                     bus.resp_result <= calc_res;
                     bus.resp_valid  <= 1'b1;
                     state           <= DONE;
                  end
               end
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result and arrival cycle are queued on accept
// and matched against every resp_valid pulse.
module tb_muldiv_seq;
   localparam int unsigned XLEN = 32;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   muldiv_seq_if #(.XLEN(XLEN)) dut_if ();

   muldiv_seq #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      p  = '0;
      case (f)
         3'd0: p = ua * ub;
         3'd1: p = sa * sb;
         3'd2: p = sa * ub;
         3'd3: p = ua * ub;
         3'd4: begin
            if (b == 0) p = '1;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, a};
            else p = sa / sb;
         end
         3'd5: p = (b == 0) ? '1 : (ua / ub);
         3'd6: begin
            if (b == 0) p = {32'd0, a};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
            else p = sa % sb;
         end
         default: p = (b == 0) ? {32'd0, a} : (ua % ub);
      endcase
      return (f inside {3'd1, 3'd2, 3'd3}) ? p[63:32] : p[31:0];
   endfunction

   // Every response must match the oldest outstanding expectation, in value and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && dut_if.resp_valid) begin
         if (sb.size() == 0) begin
            check("spurious_resp", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("result", {32'd0, dut_if.resp_result}, {32'd0, e.res});
            check("latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(dut_if.req_ready && sb.size() == 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_timeout", 64'd0, 64'd1);
   endtask

   // Issue one request; push expectation unless push=0; optionally flush during the DONE cycle.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push, input bit flush_done);
      exp_t e;
      wait_idle();
      dut_if.funct3    = f;
      dut_if.op1       = a;
      dut_if.op2       = b;
      dut_if.req_valid = 1'b1;
      e.res = exp;
      e.cyc = cyc + (is_special(f, a, b) ? 1 : XLEN + 1);
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      dut_if.req_valid = 1'b0;
      dut_if.funct3    = 3'($urandom);
      dut_if.op1       = $urandom;
      dut_if.op2       = $urandom;
      if (flush_done) begin
         dut_if.flush = 1'b1;
         @(posedge clk);
         #1;
         dut_if.flush = 1'b0;
      end
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      dut_if.req_valid = 1'b0;
      dut_if.flush     = 1'b0;
      dut_if.funct3    = '0;
      dut_if.op1       = '0;
      dut_if.op2       = '0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", {63'd0, dut_if.resp_valid}, 64'd0);
      check("rst_req_ready", {63'd0, dut_if.req_ready}, 64'd1);
      check("rst_busy", {63'd0, dut_if.busy}, 64'd0);
      check("rst_result", {32'd0, dut_if.resp_result}, 64'd0);
      rst_n = 1'b1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 1'b0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, 1'b0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0);
      do_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b1, 1'b0);
      do_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(3'd7, 32'h1234, 32'd0, 32'h1234, 1'b1, 1'b0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, 1'b0);

      // flush during the DONE cycle: the pulse still shows, then back to IDLE
      do_op(3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
      @(negedge clk);
      check("flush_done_ready", {63'd0, dut_if.req_ready}, 64'd1);

      // flush in the 5th CALC cycle: no response ever, result register untouched
      do_op(3'd0, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      dut_if.flush = 1'b1;
      @(posedge clk);
      #1;
      dut_if.flush = 1'b0;
      @(negedge clk);
      check("flush_ready", {63'd0, dut_if.req_ready}, 64'd1);
      check("flush_busy", {63'd0, dut_if.busy}, 64'd0);
      check("flush_result_held", {32'd0, dut_if.resp_result}, 64'h0000_0000_FFFF_FFFF);
      repeat (40) @(negedge clk);
      do_op(3'd0, 32'd11, 32'd13, 32'd143, 1'b1, 1'b0);

      // flush together with a request in IDLE: not accepted
      wait_idle();
      dut_if.funct3    = 3'd0;
      dut_if.op1       = 32'd2;
      dut_if.op2       = 32'd2;
      dut_if.req_valid = 1'b1;
      dut_if.flush     = 1'b1;
      @(posedge clk);
      #1;
      dut_if.req_valid = 1'b0;
      dut_if.flush     = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", {63'd0, dut_if.busy}, 64'd0);
      check("idle_flush_ready", {63'd0, dut_if.req_ready}, 64'd1);

      // reset mid-CALC discards the operation
      do_op(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_resp_valid", {63'd0, dut_if.resp_valid}, 64'd0);
      check("mid_rst_req_ready", {63'd0, dut_if.req_ready}, 64'd1);
      check("mid_rst_busy", {63'd0, dut_if.busy}, 64'd0);
      check("mid_rst_result", {32'd0, dut_if.resp_result}, 64'd0);
      rst_n = 1'b1;
      do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b1, 1'b0);

      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if (i == 5) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         do_op(f, a, b, model(f, a, b), 1'b1, 1'b0);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
